fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
- Instruction-fetch stage directly downstream of the instruction cache.
- Owns the fetch PC: drives it to the cache, accepts hit data, and buffers fetched words with their PCs in a small FIFO for the decode stage.
- Holds the PC stable for the whole of a cache line fill, and defers branch/jump redirects that arrive mid-fill so the cache never refills a line under a changing address.

Parameters:
- WORD_SIZE, 16, width of instruction word and PC.
- QUEUE_DEPTH, 2, FIFO entries (power of two, 2..8).
- RESET_PC, 16'h0000, fetch PC value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- IF_PC  output  WORD_SIZE  fetch address to the instruction cache.
- i_cache_hit  input  1  cache hit strobe; 0 while missing or filling.
- i_cache_result  input  WORD_SIZE  cache data; valid only when i_cache_hit=1.
- redirect  input  1  one-cycle request to change the fetch PC.
- redirect_pc  input  WORD_SIZE  new PC; sampled when redirect=1.
- id_stall  input  1  decode not ready; head entry is not consumed.
- inst_valid  output  1  FIFO head is valid.
- inst  output  WORD_SIZE  head instruction; 0 when empty.
- inst_pc  output  WORD_SIZE  PC of the head instruction; 0 when empty.
- queue_full  output  1  count == QUEUE_DEPTH.
- fetch_cnt  output  WORD_SIZE  number of words enqueued since reset (wraps).
- miss_stall_cnt  output  WORD_SIZE  cycles with i_cache_hit=0 since reset (wraps).

Behaviour:
- Reset (asynchronous, any time, including mid-fill or with redirect pending):
  - IF_PC=RESET_PC; FIFO emptied; state=RUN.
  - inst_valid=0, inst=0, inst_pc=0, queue_full=0, fetch_cnt=0, miss_stall_cnt=0.
- IF_PC is a register and changes only on clock edges.
- Pop:
  - pop = inst_valid & ~id_stall.
  - The head advances at the edge; inst/inst_pc are combinational from the FIFO head.
- Push, state RUN:
  - push = i_cache_hit & ~redirect & (count<QUEUE_DEPTH | pop).
  - On push, enqueue {i_cache_result, IF_PC} and set IF_PC <= IF_PC+1, with wrap 16'hFFFF -> 16'h0000.
  - On hit with the FIFO full and no pop, do not push and hold IF_PC.
- Miss: when i_cache_hit=0, hold IF_PC and do not push. The fill is in progress or starting; latency is cache-defined (5 cycles nominal).
- State RUN:
  - redirect=1 with i_cache_hit=1: flush FIFO (count=0; any pop that cycle is ignored), IF_PC <= redirect_pc, discard the current hit word.
  - redirect=1 with i_cache_hit=0: latch redirect_pc into pend_pc and go to WAIT_FILL. IF_PC is held and the FIFO is flushed immediately.
- State WAIT_FILL:
  - No pushes. Pops are impossible because the FIFO is empty.
  - Stay while i_cache_hit=0.
  - On the first cycle with i_cache_hit=1: discard the word, IF_PC <= pend_pc, return to RUN.
  - A new redirect in WAIT_FILL overwrites pend_pc; the last one wins.
  - A redirect arriving in the same cycle that WAIT_FILL exits takes priority: IF_PC <= redirect_pc.
- Latency: hit at edge N gives inst_valid=1 after edge N. Sustained throughput is 1 word/cycle on consecutive hits with ~id_stall.
- Simultaneous push and pop when full is allowed; the count is unchanged.
- Counters:
  - fetch_cnt increments on each push.
  - miss_stall_cnt increments on each cycle with i_cache_hit=0, in either state.
  - Both wrap at 2^WORD_SIZE.
- FIFO uses circular read/write pointers (log2 QUEUE_DEPTH bits) plus a count of QUEUE_DEPTH+1 states. Pointers wrap modulo QUEUE_DEPTH.

Test Plan:
- Reset, then i_cache_hit=1 for 4 cycles with results 16'hA001..A004 and id_stall=0 -> IF_PC steps 0,1,2,3,4; inst/inst_pc = A001/0 .. A004/3 one cycle after each hit; fetch_cnt=4.
- id_stall=1 with hits continuing -> after 2 pushes queue_full=1 and IF_PC stays at 2. Release id_stall -> entries pop in order PC 0,1, fetch resumes from PC 2, no word lost or duplicated.
- i_cache_hit=0 for 5 cycles at IF_PC=16'h0010 -> IF_PC stays 16'h0010, no pushes, miss_stall_cnt=5; the next hit enqueues with inst_pc=16'h0010.
- Redirect to 16'h0040 during the 2nd miss cycle -> IF_PC stays 16'h0010 until the hit, that hit word is discarded, then IF_PC=16'h0040; the FIFO is empty throughout.
- Redirect to 16'h0080 with a hit and a full FIFO -> FIFO flushed (inst_valid=0 the next cycle), IF_PC=16'h0080, fetch_cnt unchanged.
- IF_PC=16'hFFFF hit -> next IF_PC=16'h0000. Assert reset asynchronously mid-miss -> all outputs at reset values immediately, IF_PC=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the fetch PC, buffers cache hit words with their
// PCs in a small FIFO for decode, and defers redirects that land during a line fill.
module fetch_queue_unit #(
  parameter int unsigned          WORD_SIZE   = 16,
  parameter int unsigned          QUEUE_DEPTH = 2,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [WORD_SIZE-1:0] IF_PC,
  input  logic                 i_cache_hit,
  input  logic [WORD_SIZE-1:0] i_cache_result,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 id_stall,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  output logic                 queue_full,
  output logic [WORD_SIZE-1:0] fetch_cnt,
  output logic [WORD_SIZE-1:0] miss_stall_cnt
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic {
    ST_RUN,
    ST_WAIT_FILL
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] pend_q, pend_d;
  logic [WORD_SIZE-1:0] word_q [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] word_d [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] wpc_q  [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] wpc_d  [QUEUE_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WORD_SIZE-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [WORD_SIZE-1:0] miss_cnt_q, miss_cnt_d;

  logic push;
  logic pop;
  logic flush;

  // Fetch control, FIFO bookkeeping and counters.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    word_d      = word_q;
    wpc_d       = wpc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    fetch_cnt_d = fetch_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    push        = 1'b0;
    flush       = 1'b0;
    pop         = (count_q != '0) && !id_stall;

    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          flush = 1'b1;
          if (i_cache_hit) begin
            pc_d = redirect_pc;
          end else begin
            // Line fill in flight: keep the address stable until it lands.
            pend_d  = redirect_pc;
            state_d = ST_WAIT_FILL;
          end
        end else if (i_cache_hit && ((count_q < CNT_W'(QUEUE_DEPTH)) || pop)) begin
          push = 1'b1;
          pc_d = pc_q + WORD_SIZE'(1);
        end
      end
      ST_WAIT_FILL: begin
        if (i_cache_hit) begin
          pc_d    = redirect ? redirect_pc : pend_q;
          state_d = ST_RUN;
        end else if (redirect) begin
          pend_d = redirect_pc;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        word_d[wr_ptr_q] = i_cache_result;
        wpc_d[wr_ptr_q]  = pc_q;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    fetch_cnt_d = fetch_cnt_q + WORD_SIZE'(push);
    miss_cnt_d  = miss_cnt_q + WORD_SIZE'(!i_cache_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fetch_cnt_q <= '0;
      miss_cnt_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        word_q[i] <= '0;
        wpc_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      fetch_cnt_q <= fetch_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      word_q      <= word_d;
      wpc_q       <= wpc_d;
    end
  end

  // Head of queue is presented combinationally; zero when empty.
  assign IF_PC          = pc_q;
  assign inst_valid     = (count_q != '0);
  assign inst           = inst_valid ? word_q[rd_ptr_q] : '0;
  assign inst_pc        = inst_valid ? wpc_q[rd_ptr_q] : '0;
  assign queue_full     = (count_q == CNT_W'(QUEUE_DEPTH));
  assign fetch_cnt      = fetch_cnt_q;
  assign miss_stall_cnt = miss_cnt_q;

endmodule
